// File: rtl/cpu_write_sb_if.sv
// Memory-side bus of cpu_write_sb: word-wide, single-outstanding request/acknowledge.
// The master holds we/addr/wdata stable from request until the acknowledge cycle.
interface cpu_write_sb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/cpu_write_sb.sv
// Writeback stage with a FIFO store buffer draining to a request/ack memory bus; loads stall
// until older stores have drained and read data returns. Define CPU_WRITE_SB_FWD_EN for store-to-load forwarding.
module cpu_write_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = 4,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [IDX_W-1:0]  register_write_index_i,
  input  logic              register_we_i,
  input  logic              memory_we_i,
  input  logic              loadp_i,
  input  logic [ADDR_W-1:0] memory_address_i,
  input  logic [DATA_W-1:0] reg_result_i,
  input  logic [DATA_W-1:0] mem_result_i,
  output logic              stall_o,
  output logic [IDX_W-1:0]  register_write_index_o,
  output logic              register_we_o,
  output logic [DATA_W-1:0] reg_result_o,
  cpu_write_sb_if.master    bus
);

  localparam int                PTR_W    = $clog2(SB_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(SB_DEPTH);
  localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_READ
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0]   sb_data_q [SB_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic                reg_we_q, reg_we_d;
  logic [IDX_W-1:0]    reg_idx_q, reg_idx_d;
  logic [DATA_W-1:0]   reg_result_q, reg_result_d;

  logic                sb_empty, sb_full;
  logic                stall, accept, push, pop;
  logic                mem_req, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic [DATA_W-1:0]   load_data;

  assign sb_empty = (count_q == '0);
  assign sb_full  = (count_q == FULL_CNT);

`ifdef CPU_WRITE_SB_FWD_EN
  // Walk oldest to youngest so the last match wins: the youngest store to the address.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CNT_W'(i) < count_q && sb_addr_q[head_q + PTR_W'(i)] == memory_address_i) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[head_q + PTR_W'(i)];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (!sb_empty) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = sb_addr_q[head_q];
          mem_wdata = sb_data_q[head_q];
        end
        if (valid_i && loadp_i && !fwd_hit) begin
          stall     = 1'b1;
          ld_addr_d = memory_address_i;
          state_d   = sb_empty ? S_READ : S_DRAIN;
        end else if (valid_i && memory_we_i && sb_full) begin
          stall = 1'b1;
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (!sb_empty) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = sb_addr_q[head_q];
          mem_wdata = sb_data_q[head_q];
        end
        // An empty buffer here only arises when the last store completed in the detect cycle.
        if (sb_empty || (count_q == ONE_CNT && bus.mem_ack_i)) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = ld_addr_q;
        stall    = !bus.mem_ack_i;
        if (bus.mem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = valid_i && !stall;
  assign push      = accept && memory_we_i;
  assign pop       = mem_req && mem_we && bus.mem_ack_i;
  assign load_data = (state_q == S_READ) ? bus.mem_rdata_i : fwd_data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_ONE;
    if (pop)  head_d = head_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    reg_we_d     = accept && register_we_i;
    reg_idx_d    = reg_idx_q;
    reg_result_d = reg_result_q;
    if (accept) begin
      reg_idx_d    = register_write_index_i;
      reg_result_d = loadp_i ? load_data : reg_result_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ld_addr_q    <= '0;
      reg_we_q     <= 1'b0;
      reg_idx_q    <= '0;
      reg_result_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ld_addr_q    <= ld_addr_d;
      reg_we_q     <= reg_we_d;
      reg_idx_q    <= reg_idx_d;
      reg_result_q <= reg_result_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone marks valid slots, so stale data is never seen.
  always_ff @(posedge clk_i) begin
    if (push) begin
      sb_addr_q[tail_q] <= memory_address_i;
      sb_data_q[tail_q] <= mem_result_i;
    end
  end

  assign stall_o                = stall;
  assign register_we_o          = reg_we_q;
  assign register_write_index_o = reg_idx_q;
  assign reg_result_o           = reg_result_q;
  assign bus.mem_req_o          = mem_req;
  assign bus.mem_we_o           = mem_we;
  assign bus.mem_addr_o         = mem_addr;
  assign bus.mem_wdata_o        = mem_wdata;

endmodule

// File: doc/cpu_write_sb.md
# cpu_write_sb

Parametrised writeback unit with a store buffer, replacing the fixed-width, never-stalling writeback stage. Register results from the memory stage are registered into the register-file write port. Stores are queued in a FIFO store buffer that drains to a single-outstanding request/acknowledge memory bus. Loads stall the pipeline until the data returns over the same bus.

## Interface
- `DATA_W`, default 32: data and register width.
- `ADDR_W`, default 32: memory address width.
- `IDX_W`, default 4: register index width.
- `SB_DEPTH`, default 4: store-buffer entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  memory stage presents an instruction.
- `register_write_index_i`  in  IDX_W  destination register.
- `register_we_i`  in  1  instruction writes a register.
- `memory_we_i`  in  1  instruction is a store.
- `loadp_i`  in  1  instruction is a load; never set together with `memory_we_i`.
- `memory_address_i`  in  ADDR_W  load/store word address.
- `reg_result_i`  in  DATA_W  ALU result.
- `mem_result_i`  in  DATA_W  store data.
- `stall_o`  out  1  hold the memory stage; the instruction is not accepted.
- `register_write_index_o`  out  IDX_W  registered write index.
- `register_we_o`  out  1  registered write enable; one cycle per accepted instruction.
- `reg_result_o`  out  DATA_W  registered write data.
- `mem_req_o`  out  1  bus request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  ADDR_W  bus address.
- `mem_wdata_o`  out  DATA_W  bus write data.
- `mem_ack_i`  in  1  bus acknowledge; completes the current request.
- `mem_rdata_i`  in  DATA_W  read data; valid with `mem_ack_i`.

## Operation
- **Acceptance.** An instruction is accepted in a cycle with `valid_i=1` and `stall_o=0`.
- **Non-memory instruction.** Accepted immediately. Index, write enable and `reg_result_i` are registered.
- **Store.** Address and data are pushed at the FIFO tail on acceptance; `register_we_o` follows `register_we_i`.
- **Store stall.** `stall_o=1` while the buffer holds `SB_DEPTH` entries, even if a pop occurs in the same cycle.
- **Bus rules.**
  - Only word-wide accesses.
  - One request outstanding.
  - Once `mem_req_o` rises, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` hold until the `mem_ack_i` cycle.
  - A request is never withdrawn.
  - `mem_ack_i` with `mem_req_o=0` is ignored.
- **Drain.** In IDLE and DRAIN, a non-empty buffer requests a write of its head entry. Ack pops the head. FIFO order is strict.
- **Load FSM states.** IDLE, DRAIN, READ.
  - IDLE, load presented, no forward hit: go to DRAIN if the buffer is non-empty, else to READ. `stall_o=1` this cycle.
  - DRAIN: `stall_o=1`. An ack while count==1 moves to READ on the next cycle.
  - READ: `mem_req_o=1`, `mem_we_o=0`, `mem_addr_o`=load address. `stall_o=!mem_ack_i`.
  - READ, ack cycle: the load is accepted. `reg_result_o`←`mem_rdata_i` at the next edge. Return to IDLE.
- **Load result.** `reg_result_o` takes loaded data when `loadp_i=1`, else `reg_result_i`.
- **Bubble cycles.** In cycles with no acceptance, `register_we_o=0`.
- **Reset.**
  - All outputs are 0, FIFO is empty, state is IDLE.
  - Reset mid-transaction abandons the transaction. A later stray ack is ignored.

## Timing
- Non-load instruction: 1-cycle latency from acceptance to `register_we_o`.
- Load with empty buffer: detect cycle plus ≥1 READ cycle. Result appears 1 cycle after `mem_ack_i`.
- Minimum load with empty buffer and ack in the first READ cycle: result 2 cycles after `valid_i` is first presented.
- Loads wait for every older store to complete on the bus.
- Forwarded load: 1-cycle latency, no bus traffic, no stall.
- Combinational paths: `mem_ack_i`→`stall_o`; `valid_i`/`loadp_i`/address→`stall_o`.

## Configuration
- `CPU_WRITE_SB_FWD_EN` defined:
  - A load address is compared against all valid buffer entries.
  - On a hit, the youngest matching entry's data is the result, with no stall and no state change.
  - A hit does not pop the entry.
- Undefined: no comparators; every load follows the DRAIN/READ path.

## Test plan
- **ALU pass-through.** `valid_i=1`, index 3, we 1, `reg_result_i`=0x1234 → next cycle `register_we_o=1`, index 3, `reg_result_o`=0x1234, `stall_o=0`.
- **Store-buffer full.** Store 4 times with ack held low (`SB_DEPTH`=4) → 5th store sees `stall_o=1`. Ack one entry → pop; the 5th store is accepted one cycle after the pop.
- **Drain order.** Stores to 0x10/0xA, 0x14/0xB, then ack each → bus writes in order 0x10 then 0x14, with addr/data stable while waiting.
- **Load with pending stores.**
  - Setup: 2 stores queued; load 0x40; macro undefined.
  - Two write acks occur, then a read issues; ack with 0xDEAD.
  - Expect `reg_result_o`=0xDEAD, `register_we_o=1` exactly once.
- **Forwarding.** With `CPU_WRITE_SB_FWD_EN`, queue stores 0x20←1 then 0x20←2 with ack low; load 0x20 → next cycle `reg_result_o`=2, `stall_o` never high, no read request.
- **Reset during read.** Assert reset in READ → all outputs 0 immediately. After release, an ack pulse causes no write-back and no FIFO change.
